accum_drain: RTL
================

# accum_drain

Output drain for the accumulator bank. Accepts the column-skewed `read_out` strobes and `o_data` words emitted by the accumulator, where column c lags column 0 by c cycles. Deskews them into whole aligned rows, tags the final row of each tile, and buffers rows in a FIFO. The FIFO feeds the downstream output writer over a valid/ready handshake. The block sits between the accumulator and the output-feature-map memory writer.

## Interface
- `SYS_COLS`, default `sys_cols` (Config): number of columns; must be ≥ 1.
- `DATA_W`, default `W_BITWIDTH` (Config): width of one accumulator output word.
- `DEPTH`, default 8: number of FIFO row entries; must be a power of 2 and ≥ 2.

Ports (clock and reset first):
- `clk` in, 1: the single clock.
- `rst` in, 1: synchronous, active-low reset. Sampled on the rising edge of `clk`; 0 = reset.
- `read_out` in, `SYS_COLS`: per-column data-valid strobe from the accumulator, skewed.
- `o_data` in, `SYS_COLS`×`DATA_W`: per-column data from the accumulator, skewed.
- `done` in, 1: one-cycle tile-end pulse, aligned to column 0.
- `out_valid` out, 1: a FIFO head row is available.
- `out_ready` in, 1: the downstream writer accepts the head row.
- `out_data` out, `SYS_COLS`×`DATA_W`: head row, column-aligned.
- `out_last` out, 1: the head row is the final row of its tile.
- `fill` out, log2(`DEPTH`)+1: number of occupied FIFO entries.
- `overflow` out, 1: sticky flag; a row was dropped because the FIFO was full.
- `skew_err` out, 1: sticky flag; aligned column strobes disagreed.

## Operation
**Deskew**
- Column c, for both strobe and data, passes through a register delay of `SYS_COLS`-1-c cycles. Column `SYS_COLS`-1 has zero delay.
- The row-valid signal is `av` = the delayed strobe of column 0.
- If any delayed column strobe differs from `av`, `skew_err` is set and stays set until reset. The row is still processed, using `av`.
- `done` is delayed `SYS_COLS`-1 cycles to produce `tend`.

**Staging and last tagging**
- A one-row staging register holds `stg_data`, `stg_v`, and `stg_last_pend`.
- States: IDLE (`stg_v`=0), HOLD (`stg_v`=1, not yet known whether it is the last row), LASTP (`stg_v`=1, known to be last).
- IDLE:
  - `av` → load the row into staging. Go to LASTP if `tend` is also 1, else HOLD.
  - `tend` alone → ignored (empty tile; no row is produced).
- HOLD:
  - `av` and not `tend` → push staging with last=0, load the new row, stay in HOLD.
  - `av` and `tend` → push staging with last=0, load the new row, go to LASTP.
  - `tend` without `av` → push staging with last=1, go to IDLE.
- LASTP:
  - No `av` → push staging with last=1, go to IDLE.
  - `av` → push staging with last=1, load the new row into HOLD. This row starts the next tile.
- At most one FIFO push occurs per cycle.

**FIFO**
- `DEPTH` entries, each `SYS_COLS`×`DATA_W`+1 bits. Read and write pointers are log2(`DEPTH`) bits and wrap naturally.
- Pop happens when `out_valid` and `out_ready` are both 1.
- Push when full and a pop occurs in the same cycle: accepted. Occupancy is unchanged.
- Push when full and no pop: the row is dropped, `overflow` is set (sticky), and the staging FSM advances as if the push had succeeded.
- `out_valid` = (`fill` ≠ 0). `out_data` and `out_last` come from the head entry and hold steady while `out_valid`=1 and `out_ready`=0.

**Reset**
- Applies at any time, including mid-tile. It clears every delay-line strobe, `tend`, staging, both pointers, `fill`, `overflow`, and `skew_err`. The FSM goes to IDLE.
- Data-path delay registers need no reset.

## Timing
- Reset values: `out_valid`=0, `out_last`=0, `fill`=0, `overflow`=0, `skew_err`=0. `out_data` is don't-care.
- Column 0 strobe at cycle t → `av` at t+`SYS_COLS`-1 → row in staging at t+`SYS_COLS`.
- A staged row is pushed on the cycle the next `av` or `tend` arrives. It is visible on `out_*` one cycle after the push.
- Minimum latency from column-0 strobe to `out_valid`, for the last row: `SYS_COLS`+1 cycles.
- Throughput is one row per cycle when `out_ready` is held at 1.
- `fill` updates one cycle after a push or pop; a simultaneous push and pop leaves it unchanged.
- `SYS_COLS`=1: no delay registers; `tend` equals `done`.

## Test plan
- **Single row, `SYS_COLS`=4:** column c strobe at cycle 10+c with data 0x10+c; `done` at 10; `out_ready`=1. Required: `out_valid` at cycle 15 with data {0x13,0x12,0x11,0x10} and `out_last`=1; `fill` returns to 0.
- **Back-to-back tile:** 3 rows on consecutive cycles, `done` on row 3, then a new tile row 2 cycles later. Required: `out_last` sequence 0,0,1,0 in order, with data unchanged.
- **Backpressure:** `out_ready`=0 while 8 rows enter with `DEPTH`=8. Required: `fill`=8 and `overflow`=0. A 9th row with no pop sets `overflow`=1, and the first 8 rows later drain intact.
- **Push and pop while full:** `fill`=8, `out_ready`=1, row arriving. Required: `fill` stays 8 and `overflow` stays 0.
- **Skew fault:** column 2 strobe arrives 1 cycle late. Required: `skew_err`=1 and it stays 1 until reset.
- **Reset mid-tile:** `rst`=0 for 1 cycle with 2 rows staged or buffered. Required: the next cycle shows `out_valid`=0, `fill`=0, and both flags 0; no stale row ever appears.

Source files
------------

// File: rtl/accum_drain.sv
`default_nettype none
// ============================================================================
// accum_drain : deskews column-skewed accumulator rows, tags the final row of
//               each tile and buffers rows in a FIFO toward the output writer.
// Revision    : 1.0
// ============================================================================
module accum_drain #(
  parameter int SYS_COLS = 4,
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [SYS_COLS-1:0]        read_out,
  input  logic [SYS_COLS*DATA_W-1:0] o_data,
  input  logic                       done,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [SYS_COLS*DATA_W-1:0] out_data,
  output logic                       out_last,
  output logic [$clog2(DEPTH):0]     fill,
  output logic                       overflow,
  output logic                       skew_err
);

  localparam int AW    = $clog2(DEPTH);
  localparam int ROW_W = SYS_COLS * DATA_W;
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE_CNT  = (AW+1)'(1);
  localparam logic [AW-1:0] ONE_PTR  = AW'(1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_LASTP = 2'd2;

  logic [SYS_COLS-1:0] dly_v;
  logic [ROW_W-1:0]    dly_d;
  logic                row_v;
  logic                tend;

  // Column c is delayed SYS_COLS-1-c cycles so all columns line up with column 0.
  for (genvar c = 0; c < SYS_COLS; c++) begin : g_col
    localparam int DLY = SYS_COLS - 1 - c;
    if (DLY == 0) begin : g_direct
      assign dly_v[c]                  = read_out[c];
      assign dly_d[c*DATA_W +: DATA_W] = o_data[c*DATA_W +: DATA_W];
    end else begin : g_delay
      logic [DLY-1:0]             v_q;
      logic [DLY-1:0][DATA_W-1:0] d_q;
      always_ff @(posedge clk) begin
        if (!rst) begin
          v_q <= '0;
        end else begin
          v_q[0] <= read_out[c];
          for (int k = 1; k < DLY; k++) v_q[k] <= v_q[k-1];
        end
      end
      always_ff @(posedge clk) begin
        d_q[0] <= o_data[c*DATA_W +: DATA_W];
        for (int k = 1; k < DLY; k++) d_q[k] <= d_q[k-1];
      end
      assign dly_v[c]                  = v_q[DLY-1];
      assign dly_d[c*DATA_W +: DATA_W] = d_q[DLY-1];
    end
  end

  if (SYS_COLS == 1) begin : g_tend_direct
    assign tend = done;
  end else begin : g_tend_delay
    logic [SYS_COLS-2:0] tend_q;
    always_ff @(posedge clk) begin
      if (!rst) begin
        tend_q <= '0;
      end else begin
        tend_q[0] <= done;
        for (int k = 1; k < SYS_COLS-1; k++) tend_q[k] <= tend_q[k-1];
      end
    end
    assign tend = tend_q[SYS_COLS-2];
  end

  assign row_v = dly_v[0];

  logic skew_q;
  always_ff @(posedge clk) begin
    if (!rst) skew_q <= 1'b0;
    else      skew_q <= skew_q | (|(dly_v ^ {SYS_COLS{row_v}}));
  end

  logic [1:0]       state_q, state_d;
  logic             push, push_last, load;
  logic [ROW_W-1:0] stg_data_q;

  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (row_v) state_d = tend ? ST_LASTP : ST_HOLD;
      ST_HOLD: begin
        if (row_v)     state_d = tend ? ST_LASTP : ST_HOLD;
        else if (tend) state_d = ST_IDLE;
      end
      ST_LASTP: state_d = row_v ? ST_HOLD : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    push      = 1'b0;
    push_last = 1'b0;
    load      = 1'b0;
    case (state_q)
      ST_IDLE: load = row_v;
      ST_HOLD: begin
        push      = row_v | tend;
        push_last = ~row_v & tend;
        load      = row_v;
      end
      ST_LASTP: begin
        push      = 1'b1;
        push_last = 1'b1;
        load      = row_v;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (load) stg_data_q <= dly_d;
  end

  logic [ROW_W:0]  mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     fill_q, fill_d;
  logic            ovf_q;
  logic            full, pop, wr_en;
  logic [ROW_W:0]  head;

  assign full  = (fill_q == FULL_CNT);
  assign pop   = out_valid & out_ready;
  // A push into a full FIFO still lands when the head leaves on the same edge.
  assign wr_en = push & (~full | pop);

  always_comb begin
    fill_d = fill_q;
    if (wr_en && !pop)      fill_d = fill_q + ONE_CNT;
    else if (!wr_en && pop) fill_d = fill_q - ONE_CNT;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {push_last, stg_data_q};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + ONE_PTR;
      if (pop)   rd_ptr_q <= rd_ptr_q + ONE_PTR;
      fill_q <= fill_d;
      ovf_q  <= ovf_q | (push & full & ~pop);
    end
  end

  assign head      = mem_q[rd_ptr_q];
  assign out_valid = (fill_q != '0);
  assign out_data  = head[ROW_W-1:0];
  assign out_last  = out_valid & head[ROW_W];
  assign fill      = fill_q;
  assign overflow  = ovf_q;
  assign skew_err  = skew_q;

endmodule
`default_nettype wire
